// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of one ripple slice; the datapath walks the operands in steps of this size.
    localparam int NIB_W = 4;

    // Index width needed to address every nibble of a width-bit operand.
    function automatic int nib_idx_w(input int width);
        return (width / NIB_W <= 1) ? 1 : $clog2(width / NIB_W);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand (valid/ready) and result (valid/ready) channels of the nibble-serial adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/nibble_serial_adder_add4.sv
// Combinational 4-bit ripple-carry slice built from four full-adder cells.
module nibble_add4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]     = x[i] ^ y[i] ^ c[i];
        assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one shared 4-bit ripple slice processes one nibble per cycle,
// LSB first, with the carry held in a register between cycles.
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = nib_idx_w(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [NIB_W-1:0] x_nib;
    logic [NIB_W-1:0] y_nib;
    logic [NIB_W-1:0] s_nib;
    logic             c_nib;
    logic             accept;

    // in_ready_q is only ever high in IDLE, so it alone qualifies the capture.
    assign accept = bus.in_valid && in_ready_q;

    // Select the current operand nibbles for the shared slice.
    assign x_nib = a_r[NIB_W*idx +: NIB_W];
    assign y_nib = b_r[NIB_W*idx +: NIB_W];

    nibble_add4 u_add4 (
        .x  (x_nib),
        .y  (y_nib),
        .ci (carry_q),
        .s  (s_nib),
        .co (c_nib)
    );

    // Operand capture on the accepting edge.
    // NOTE: pure datapath registers need no reset; every use is preceded by a capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= bus.a;
            b_r <= bus.b;
        end
    end

    // Control FSM with registered handshake outputs, carry, index and sum.
    // NOTE: state is written with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        carry_q    <= bus.cin;
                        idx        <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_q[NIB_W*idx +: NIB_W] <= s_nib;
                    carry_q                   <= c_nib;
                    if (idx == LAST_IDX) begin
                        cout_q      <= c_nib;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed cases, then
// randomized traffic against an arithmetic reference model.
module tb_nibble_serial_adder;
    localparam int WIDTH  = 16;
    localparam int NIB    = WIDTH / 4;
    localparam int N_RAND = 1000;
    localparam int BOUND  = 50;

    logic clk = 1'b0;
    logic rst_n;

    // 10-time-unit clock.
    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bif ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full-precision unsigned sum; bit WIDTH is the carry out.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic ci);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands once in_ready is seen, then step past the accepting edge.
    task automatic send(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input bit hold);
        int n = 0;
        while (!bif.in_ready && n < BOUND) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, bif.in_ready, 1);
        bif.a        = a;
        bif.b        = b;
        bif.cin      = ci;
        bif.in_valid = 1'b1;
        tick();
        if (!hold) bif.in_valid = 1'b0;
    endtask

    // Count edges from the current point until out_valid is seen.
    task automatic wait_result(input string tag, output int lat);
        lat = 0;
        while (!bif.out_valid && lat < BOUND) begin
            tick();
            lat++;
        end
        check({tag, "_valid"}, bif.out_valid, 1);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic ci);
        logic [WIDTH:0] exp;
        exp = ref_add(a, b, ci);
        check({tag, "_sum"}, bif.sum, exp[WIDTH-1:0]);
        check({tag, "_cout"}, bif.cout, exp[WIDTH]);
    endtask

    // Directed sequence followed by randomized traffic.
    initial begin
        int lat;
        int sent;
        int got;
        int cyc;
        bit acc;
        bit dlv;
        logic [WIDTH:0] q[$];
        logic [WIDTH:0] exp;

        bif.in_valid  = 1'b0;
        bif.a         = '0;
        bif.b         = '0;
        bif.cin       = 1'b0;
        bif.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset state.
        #1;
        check("rst_in_ready", bif.in_ready, 0);
        check("rst_out_valid", bif.out_valid, 0);
        check("rst_sum", bif.sum, 0);
        check("rst_cout", bif.cout, 0);
        #11 rst_n = 1'b1;
        check("rel_in_ready_low", bif.in_ready, 0);
        tick();
        check("rel_in_ready_high", bif.in_ready, 1);

        // Overflow: FFFF + 0001, latency exactly NIB edges.
        send("ovf", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("ovf_busy", bif.in_ready, 0);
        wait_result("ovf", lat);
        check("ovf_latency", lat, NIB);
        check("ovf_sum_const", bif.sum, 16'h0000);
        check("ovf_cout_const", bif.cout, 1);
        tick();
        check("ovf_hs_valid", bif.out_valid, 0);
        check("ovf_hs_ready", bif.in_ready, 1);

        send("mix", 16'h1234, 16'h4321, 1'b1, 1'b0);
        wait_result("mix", lat);
        check("mix_sum_const", bif.sum, 16'h5556);
        check_result("mix", 16'h1234, 16'h4321, 1'b1);
        tick();

        send("msb", 16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_result("msb", lat);
        check_result("msb", 16'h8000, 16'h8000, 1'b0);
        tick();

        // Backpressure: result held for 5 cycles; new operands offered meanwhile are ignored.
        bif.out_ready = 1'b0;
        send("bp", 16'h00FF, 16'h0F01, 1'b0, 1'b0);
        wait_result("bp", lat);
        bif.a        = 16'h1111;
        bif.b        = 16'h2222;
        bif.cin      = 1'b0;
        bif.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", bif.out_valid, 1);
            check("bp_hold_ready", bif.in_ready, 0);
            check_result("bp_hold", 16'h00FF, 16'h0F01, 1'b0);
        end
        bif.out_ready = 1'b1;
        tick();
        check("bp_hs_valid", bif.out_valid, 0);
        check("bp_hs_ready", bif.in_ready, 1);
        tick();
        bif.in_valid = 1'b0;
        check("bp_next_busy", bif.in_ready, 0);
        wait_result("bp_next", lat);
        check_result("bp_next", 16'h1111, 16'h2222, 1'b0);
        tick();

        // in_valid held with changing operands during RUN.
        send("hold", 16'h0A0A, 16'h5050, 1'b1, 1'b1);
        bif.a   = 16'hFFFF;
        bif.b   = 16'hFFFF;
        bif.cin = 1'b1;
        wait_result("hold", lat);
        check("hold_latency", lat, NIB);
        check_result("hold", 16'h0A0A, 16'h5050, 1'b1);
        tick();
        check("hold_hs_valid", bif.out_valid, 0);
        check("hold_idle_ready", bif.in_ready, 1);
        tick();
        bif.in_valid = 1'b0;
        check("hold2_busy", bif.in_ready, 0);
        wait_result("hold2", lat);
        check_result("hold2", 16'hFFFF, 16'hFFFF, 1'b1);
        tick();

        // Asynchronous reset mid-RUN (two nibbles done).
        send("arst", 16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        tick();
        check("arst_pre_valid", bif.out_valid, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", bif.out_valid, 0);
        check("arst_sum", bif.sum, 0);
        check("arst_cout", bif.cout, 0);
        check("arst_in_ready", bif.in_ready, 0);
        #3 rst_n = 1'b1;
        tick();
        check("arst_rel_ready", bif.in_ready, 1);
        send("post", 16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_result("post", lat);
        check("post_sum_const", bif.sum, 16'h0002);
        check_result("post", 16'h0001, 16'h0001, 1'b0);
        tick();

        // Randomized traffic with gaps on both sides against a queue of model results.
        sent = 0;
        got  = 0;
        cyc  = 0;
        bif.in_valid = 1'b0;
        while (got < N_RAND && cyc < 60000) begin
            if (!bif.in_valid && sent < N_RAND && $urandom_range(0, 2) != 0) begin
                bif.a        = WIDTH'($urandom());
                bif.b        = WIDTH'($urandom());
                bif.cin      = 1'($urandom_range(0, 1));
                bif.in_valid = 1'b1;
            end
            bif.out_ready = ($urandom_range(0, 3) != 0);
            if (bif.in_ready) check("rand_in_valid_known", 32'($isunknown(bif.in_valid)), 0);
            acc = bif.in_valid && bif.in_ready;
            dlv = bif.out_valid && bif.out_ready;
            if (dlv) begin
                check("rand_expected_pending", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp = q.pop_front();
                    check("rand_sum", bif.sum, exp[WIDTH-1:0]);
                    check("rand_cout", bif.cout, exp[WIDTH]);
                end
                got++;
            end
            if (acc) q.push_back(ref_add(bif.a, bif.b, bif.cin));
            tick();
            cyc++;
            if (acc) begin
                sent++;
                bif.in_valid = 1'b0;
            end
        end
        check("rand_sent", sent, N_RAND);
        check("rand_got", got, N_RAND);
        check("rand_q_empty", q.size(), 0);
        check("rand_no_extra", bif.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
